// File: rtl/cascade_ctrl.sv
// cascade_ctrl: clocked INTA-sequence cascade sequencer for an 8259A-style PIC.
// In the master role it drives the CAS bus with the acknowledged IR level
// when a slave sits on that input. In the slave role it matches CAS against
// its own ID and grants vector release.
// Build option: define CASCADE_8080_EN to honour upm and build the
// three-pulse ACK3 path. Without it, every sequence is two-pulse.
module cascade_ctrl #(
    parameter int CAS_W = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                inta_n,
    input  logic                SPENn,
    input  logic                buff,
    input  logic                ms_sel,
    input  logic                sngl,
    input  logic                upm,
    input  logic [2**CAS_W-1:0] slave_map,
    input  logic [CAS_W-1:0]    slave_id,
    input  logic                ack_valid,
    input  logic [CAS_W-1:0]    ack_level,
    input  logic [CAS_W-1:0]    cas_in,
    output logic [CAS_W-1:0]    cas_out,
    output logic                cas_oe,
    output logic                is_master,
    output logic                CLsig,
    output logic                vec_en,
    output logic [1:0]          byte_sel,
    output logic                en_n
);

    localparam int NUM_IR = 2**CAS_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK1 = 2'd1,
        ACK2 = 2'd2,
        ACK3 = 2'd3
    } state_t;

    state_t           state;
    logic             inta_q;      // previous inta_n sample
    logic             run;         // low for the first cycle out of reset
    logic             seq_master;  // role frozen for the current sequence
    logic [CAS_W-1:0] lvl;

    logic             fall;
    logic             rise;
    logic             upm_eff;
    logic             role_now;
    logic             hit_now;
    logic             match_now;
    logic             grant;
    logic             vec_hold;
    logic [CAS_W-1:0] lvl_now;

    // An edge seen in the cycle that reset releases is dropped via run.
    assign fall     = run & inta_q & ~inta_n;
    assign rise     = run & ~inta_q & inta_n;
    assign role_now = sngl | (buff ? ms_sel : SPENn);
    // No pending winner behaves like a spurious request on the top level.
    assign lvl_now  = ack_valid ? ack_level : CAS_W'(NUM_IR - 1);
    assign hit_now  = is_master & ~sngl & slave_map[lvl_now];
    assign match_now = ~seq_master & (cas_in == slave_id);
    // Master vectors itself only when no slave is addressed; a slave needs a match.
    assign grant    = seq_master ? ~cas_oe : CLsig;
    assign vec_hold = grant & ~inta_n;

`ifdef CASCADE_8080_EN
    assign upm_eff = upm;
`else
    // Two-pulse only: upm stays referenced but cannot change the result.
    assign upm_eff = upm | 1'b1;
`endif

    // Sequencer FSM with all outputs registered.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            inta_q     <= 1'b1;
            run        <= 1'b0;
            seq_master <= 1'b0;
            lvl        <= '0;
            cas_out    <= '0;
            cas_oe     <= 1'b0;
            is_master  <= 1'b0;
            CLsig      <= 1'b0;
            vec_en     <= 1'b0;
            byte_sel   <= 2'd0;
            en_n       <= 1'b1;
        end else begin
            inta_q    <= inta_n;
            run       <= 1'b1;
            is_master <= role_now;
            case (state)
                IDLE: begin
                    vec_en <= 1'b0;
                    en_n   <= 1'b1;
                    if (fall) begin
                        state      <= ACK1;
                        byte_sel   <= 2'd1;
                        lvl        <= lvl_now;
                        seq_master <= is_master;
                        cas_oe     <= hit_now;
                        cas_out    <= hit_now ? lvl_now : '0;
                    end
                end
                ACK1: begin
                    cas_out <= cas_oe ? lvl : '0;
                    if (fall) begin
                        state    <= ACK2;
                        byte_sel <= 2'd2;
                        CLsig    <= match_now;
                        vec_en   <= seq_master ? ~cas_oe : match_now;
                        en_n     <= buff ? ~(seq_master ? ~cas_oe : match_now) : 1'b1;
                    end else begin
                        vec_en <= 1'b0;
                        en_n   <= 1'b1;
                    end
                end
                ACK2: begin
                    cas_out <= cas_oe ? lvl : '0;
                    if (upm_eff && rise) begin
                        state    <= IDLE;
                        byte_sel <= 2'd0;
                        cas_oe   <= 1'b0;
                        cas_out  <= '0;
                        CLsig    <= 1'b0;
                        vec_en   <= 1'b0;
                        en_n     <= 1'b1;
`ifdef CASCADE_8080_EN
                    end else if (!upm_eff && fall) begin
                        state    <= ACK3;
                        byte_sel <= 2'd3;
                        vec_en   <= grant;
                        en_n     <= buff ? ~grant : 1'b1;
`endif
                    end else begin
                        vec_en <= vec_hold;
                        en_n   <= buff ? ~vec_hold : 1'b1;
                    end
                end
                default: begin
`ifdef CASCADE_8080_EN
                    cas_out <= cas_oe ? lvl : '0;
                    if (rise) begin
`endif
                        state    <= IDLE;
                        byte_sel <= 2'd0;
                        cas_oe   <= 1'b0;
                        cas_out  <= '0;
                        CLsig    <= 1'b0;
                        vec_en   <= 1'b0;
                        en_n     <= 1'b1;
`ifdef CASCADE_8080_EN
                    end else begin
                        vec_en <= vec_hold;
                        en_n   <= buff ? ~vec_hold : 1'b1;
                    end
`endif
                end
            endcase
        end
    end

endmodule

// File: doc/cascade_ctrl.md
# cascade_ctrl

Parametrised cascade sequencer for the 8259A-style PIC. It replaces the purely combinational CAS comparator with a clocked INTA-sequence state machine. In master role it drives the CAS bus with the acknowledged IR level when a slave sits on that input. In slave role it matches the CAS bus against its own ID and grants vector release. It sits between the priority resolver / ICW registers and the data-bus buffer control.

## Interface
Parameters:
- CAS_W, 3, CAS bus width; number of IR inputs NUM_IR = 2**CAS_W (localparam).

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high reset.
- inta_n  in  1  interrupt-acknowledge strobe, active-low; already synchronous to clk.
- SPENn  in  1  SP/EN strap; 1 = master when buff=0.
- buff  in  1  buffered mode (ICW4 BUF).
- ms_sel  in  1  ICW4 M/S; 1 = master, used only when buff=1.
- sngl  in  1  ICW1 SNGL; 1 = no cascade.
- upm  in  1  ICW4 µPM; 1 = 8086 two-pulse, 0 = 8080 three-pulse (see Configuration).
- slave_map  in  NUM_IR  master ICW3: bit i = slave on IR i.
- slave_id  in  CAS_W  slave ICW3 ID.
- ack_valid  in  1  resolver has a pending winner.
- ack_level  in  CAS_W  resolver winning IR level.
- cas_in  in  CAS_W  sampled CAS bus.
- cas_out  out  CAS_W  CAS drive value.
- cas_oe  out  1  CAS output enable.
- is_master  out  1  resolved role.
- CLsig  out  1  slave CAS match.
- vec_en  out  1  this device drives the vector byte now.
- byte_sel  out  2  current INTA pulse number, 1..3; 0 when idle.
- en_n  out  1  buffer enable, active-low.

## Operation
- Role register: is_master <= sngl | (buff ? ms_sel : SPENn), updated every cycle.
- Falling edge = inta_n 0 while previous sample 1; rising edge = inverse. Both use a registered copy of inta_n. The copy resets to 1.
- States: IDLE -> ACK1 on 1st falling edge; ACK1 -> ACK2 on 2nd falling edge; ACK2 -> IDLE on rising edge if upm=1, else -> ACK3 on 3rd falling edge; ACK3 -> IDLE on rising edge.
- At 1st falling edge the lvl register latches ack_valid ? ack_level : NUM_IR-1 (spurious IR7 equivalent).
- Master, cascade hit (sngl=0 and slave_map[lvl]=1): cas_out=lvl and cas_oe=1 from ACK1 until IDLE. Master never asserts vec_en for that sequence.
- Master, no hit, or sngl=1: cas_oe stays 0. vec_en=1 while inta_n low in ACK2/ACK3.
- Slave: at 2nd falling edge, CLsig <= (cas_in == slave_id). It holds until IDLE. vec_en=1 while inta_n low in ACK2/ACK3 only if CLsig=1.
- byte_sel = 1/2/3 in ACK1/ACK2/ACK3, 0 in IDLE.
- en_n = ~vec_en when buff=1. en_n is held at 1 when buff=0, because the pin is then an input.
- Role change mid-sequence is ignored. The role is latched at the 1st falling edge.

## Timing
- Reset values: cas_out=0, cas_oe=0, is_master=0, CLsig=0, vec_en=0, byte_sel=0, en_n=1, state=IDLE, lvl=0.
- Edge detected in cycle k: the state, cas_oe and CLsig update at the clk edge ending cycle k and are visible in k+1.
- vec_en rises one cycle after the vector-pulse falling edge and falls one cycle after its rising edge.
- A reset asserted mid-sequence clears all outputs immediately (asynchronously); the next sequence starts clean.
- A falling edge in the same cycle that reset deasserts is ignored.

## Configuration
- CASCADE_8080_EN defined: the upm input is honoured and the three-pulse ACK3 path exists. byte_sel reaches 3.
- CASCADE_8080_EN undefined: upm is ignored and treated as 1. ACK3 is not synthesised. Sequences are always two-pulse.

## Test plan
- Reset: assert reset mid-ACK1 -> all outputs at reset values the same cycle; state IDLE.
- Master cascade: SPENn=1, buff=0, slave_map=8'h04, ack_level=2, two INTA pulses -> cas_out=3'b010, cas_oe=1 from cycle after 1st edge to end; vec_en never 1.
- Master local: slave_map=0, ack_level=5 -> cas_oe=0; vec_en=1 during 2nd pulse only; en_n=1.
- Slave match, buffered: buff=1, ms_sel=0, slave_id=3'b001, cas_in=3'b001 -> CLsig=1 after 2nd edge; vec_en=1 and en_n=0 during 2nd pulse. With cas_in=3'b011 -> CLsig=0, vec_en=0.
- Spurious: ack_valid=0, master, slave_map=8'h80 -> cas_out=3'b111, cas_oe=1.
- CASCADE_8080_EN, upm=0, master local: three pulses -> byte_sel 1,2,3; vec_en during pulses 2 and 3; IDLE after 3rd rising edge.
